// File: rtl/ysyx_22050854_mul_sched_pkg.sv
// Shared constants for the multiply scheduler: funct3 ops, signedness codes, FSM states.
// Reuse buffer is compiled in with YSYX_22050854_MUL_REUSE_EN.
package ysyx_22050854_mul_sched_pkg;
  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;

  localparam logic [1:0] SGN_SS = 2'b11;
  localparam logic [1:0] SGN_SU = 2'b10;
  localparam logic [1:0] SGN_UU = 2'b00;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BUSY  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  typedef struct packed {
    logic [63:0] hi;
    logic [63:0] lo;
  } prod_t;

  function automatic logic [1:0] op_sgn(input logic [1:0] op);
    case (op)
      OP_MULHSU[1:0]: op_sgn = SGN_SU;
      OP_MULHU[1:0]:  op_sgn = SGN_UU;
      default:        op_sgn = SGN_SS;
    endcase
  endfunction

  // Word ops return the sign-extended low word; MUL the low half; all MULH* the high half.
  function automatic logic [63:0] sel_res(input logic [1:0] op, input logic word, input prod_t p);
    if (word)                    sel_res = {{32{p.lo[31]}}, p.lo[31:0]};
    else if (op == OP_MUL[1:0])  sel_res = p.lo;
    else                         sel_res = p.hi;
  endfunction
endpackage

// File: rtl/ysyx_22050854_mul_sched_if.sv
// EXU/WBU and multiplier-side signals of the multiply scheduler.
interface ysyx_22050854_mul_sched_if;
  logic        ex_valid;
  logic [2:0]  ex_op;
  logic        ex_word;
  logic [63:0] ex_rs1;
  logic [63:0] ex_rs2;
  logic        flush;
  logic        ex_stall;
  logic        wb_valid;
  logic        wb_ready;
  logic [63:0] wb_data;
  logic        mul_valid;
  logic        mulw;
  logic [1:0]  mul_signed;
  logic [63:0] multiplicand;
  logic [63:0] multiplier;
  logic        mul_ready;
  logic        out_valid;
  logic [63:0] result_hi;
  logic [63:0] result_lo;

  modport slave (
    input  ex_valid, ex_op, ex_word, ex_rs1, ex_rs2, flush, wb_ready,
           mul_ready, out_valid, result_hi, result_lo,
    output ex_stall, wb_valid, wb_data, mul_valid, mulw, mul_signed,
           multiplicand, multiplier
  );

  modport master (
    output ex_valid, ex_op, ex_word, ex_rs1, ex_rs2, flush, wb_ready,
           mul_ready, out_valid, result_hi, result_lo,
    input  ex_stall, wb_valid, wb_data, mul_valid, mulw, mul_signed,
           multiplicand, multiplier
  );
endinterface

// File: rtl/ysyx_22050854_mul_reuse_buf.sv
// Single-entry product reuse buffer: operands latched at issue, committed with the product.
module ysyx_22050854_mul_reuse_buf
  import ysyx_22050854_mul_sched_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        cap,
  input  logic [63:0] rs1,
  input  logic [63:0] rs2,
  input  logic [1:0]  sgn,
  input  logic        word,
  input  logic        is_mul,
  input  logic        commit,
  input  prod_t       prod_in,
  output logic        hit,
  output prod_t       prod
);
  logic [63:0] p_rs1, p_rs2, b_rs1, b_rs2;
  logic [1:0]  p_sgn, b_sgn;
  logic        vld;

  // Low half is signedness-independent, so MUL hits on any stored signedness.
  assign hit = vld & ~word & (rs1 == b_rs1) & (rs2 == b_rs2) & ((sgn == b_sgn) | is_mul);

  always_ff @(posedge clock) begin
    if (reset) begin
      p_rs1 <= '0; p_rs2 <= '0; p_sgn <= '0;
      b_rs1 <= '0; b_rs2 <= '0; b_sgn <= '0;
      prod  <= '0; vld   <= 1'b0;
    end else begin
      if (cap) begin
        p_rs1 <= rs1; p_rs2 <= rs2; p_sgn <= sgn;
      end
      if (commit) begin
        b_rs1 <= p_rs1; b_rs2 <= p_rs2; b_sgn <= p_sgn;
        prod  <= prod_in; vld <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/ysyx_22050854_mul_sched.sv
// Multiply scheduler between EXU/WBU and an external multiplier (IDLE/BUSY/DRAIN/DONE).
// Define YSYX_22050854_MUL_REUSE_EN to add the product reuse buffer.
module ysyx_22050854_mul_sched
  import ysyx_22050854_mul_sched_pkg::*;
(
  input logic                       clock,
  input logic                       reset,
  ysyx_22050854_mul_sched_if.slave  bus
);
  logic [1:0]  state, op_q;
  logic        word_q, req, idle_go, hit;
  logic [63:0] wb_q, hit_data;
  logic [1:0]  sgn;
  prod_t       res;

  assign sgn     = op_sgn(bus.ex_op[1:0]);
  assign res     = '{hi: bus.result_hi, lo: bus.result_lo};
  assign req     = bus.ex_valid & ~bus.ex_op[2] & ~bus.flush;
  assign idle_go = (state == S_IDLE) & req & ~reset;

`ifdef YSYX_22050854_MUL_REUSE_EN
  prod_t hit_prod;
  ysyx_22050854_mul_reuse_buf u_reuse (
    .clock   (clock),
    .reset   (reset),
    .cap     (bus.mul_valid),
    .rs1     (bus.ex_rs1),
    .rs2     (bus.ex_rs2),
    .sgn     (sgn),
    .word    (bus.ex_word),
    .is_mul  (bus.ex_op == OP_MUL),
    .commit  ((state == S_BUSY) & bus.out_valid & ~bus.flush & ~word_q),
    .prod_in (res),
    .hit     (hit),
    .prod    (hit_prod)
  );
  assign hit_data = sel_res(bus.ex_op[1:0], 1'b0, hit_prod);
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  assign bus.mul_valid    = idle_go & bus.mul_ready & ~hit;
  assign bus.mulw         = bus.ex_word;
  assign bus.mul_signed   = sgn;
  assign bus.multiplicand = bus.ex_rs1;
  assign bus.multiplier   = bus.ex_rs2;
  assign bus.wb_valid     = (state == S_DONE);
  assign bus.wb_data      = wb_q;
  assign bus.ex_stall     = bus.ex_valid & ~bus.ex_op[2] & ~(bus.wb_valid & bus.wb_ready) & ~bus.flush;

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= S_IDLE;
      wb_q   <= '0;
      op_q   <= '0;
      word_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE:
          if (idle_go && hit) begin
            state <= S_DONE;
            wb_q  <= hit_data;
          end else if (bus.mul_valid) begin
            state  <= S_BUSY;
            op_q   <= bus.ex_op[1:0];
            word_q <= bus.ex_word;
          end
        // A flush coinciding with the result has nothing left to drain.
        S_BUSY:
          if (bus.out_valid) begin
            state <= bus.flush ? S_IDLE : S_DONE;
            if (!bus.flush) wb_q <= sel_res(op_q, word_q, res);
          end else if (bus.flush) begin
            state <= S_DRAIN;
          end
        S_DRAIN:
          if (bus.out_valid) state <= S_IDLE;
        default:
          if (bus.flush || bus.wb_ready) state <= S_IDLE;
      endcase
    end
  end
endmodule
